// File: rtl/floatp2fixedp_seq.sv
// floatp2fixedp_seq: sequential IEEE-754 single to signed Q16.16 converter.
// The significand is aligned by a 1-bit-per-cycle right shifter, then rounded
// to nearest-even. Out-of-range values saturate, and NaN is flagged.
// The unit holds one conversion at a time and accepts no new input until the
// current result has been taken.
module floatp2fixedp_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] float32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fixedq16,
  output logic        ovf,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ROUND, S_OUT} state_t;
  typedef enum logic [1:0] {C_NORM, C_SAT, C_NAN, C_ZERO} class_t;

  state_t             r_state;
  state_t             w_next;
  class_t             r_class;
  class_t             w_class;
  logic               r_sign;
  logic        [31:0] r_work;
  logic               r_guard;
  logic               r_sticky;
  logic        [4:0]  r_cnt;
  logic signed [31:0] r_fixed;
  logic               r_ovf;
  logic               r_inv;
  logic               r_inex;

  logic        [7:0]  w_exp;
  logic        [22:0] w_man;
  logic        [23:0] w_sig;
  logic        [31:0] w_work;
  logic        [4:0]  w_cnt;
  logic               w_sticky;
  logic               w_accept;
  logic        [31:0] w_mag;
  logic signed [31:0] w_res;

  // Round-to-nearest-even increment applied to the aligned magnitude.
  function automatic logic [31:0] f_round(input logic [31:0] work, input logic guard,
                                          input logic sticky);
    logic inc;
    inc = guard & (sticky | work[0]);
    return work + {31'd0, inc};
  endfunction

  // Saturated Q16.16 extreme for the given sign.
  function automatic logic signed [31:0] f_sat(input logic sign);
    return sign ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  endfunction

  assign w_exp    = float32[30:23];
  assign w_man    = float32[22:0];
  assign w_sig    = {1'b1, w_man};
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_mag    = f_round(r_work, r_guard, r_sticky);
  assign w_res    = r_sign ? -$signed(w_mag) : $signed(w_mag);

  assign fixedq16 = r_fixed;
  assign ovf      = r_ovf;
  assign invalid  = r_inv;
  assign inexact  = r_inex;

  // Classify the incoming operand and pre-position the significand.
  always_comb begin
    w_class  = C_NORM;
    w_work   = {8'd0, w_sig};
    w_cnt    = 5'd0;
    w_sticky = 1'b0;
    if (w_exp == 8'hFF) begin
      w_class = (w_man != 23'd0) ? C_NAN : C_SAT;
    end else if (w_exp >= 8'd142) begin
      // -32768.0 is the one representable value at this exponent.
      if (float32[31] && (w_exp == 8'd142) && (w_man == 23'd0))
        w_work = 32'h8000_0000;
      else
        w_class = C_SAT;
    end else if (w_exp == 8'd0) begin
      w_class  = C_ZERO;
      w_sticky = (w_man != 23'd0);
    end else if (w_exp >= 8'd135) begin
      w_work = {8'd0, w_sig} << (w_exp - 8'd134);
    end else begin
      // Beyond 26 shifts the result is zero and only stickiness matters.
      w_cnt = (w_exp <= 8'd108) ? 5'd26 : 5'(8'd134 - w_exp);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ALIGN;
      end
      S_ALIGN: if (r_cnt == 5'd0) w_next = S_ROUND;
      S_ROUND: w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Load on accept, then shift right one bit per ALIGN cycle collecting guard/sticky.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sign   <= float32[31];
      r_class  <= w_class;
      r_work   <= w_work;
      r_cnt    <= w_cnt;
      r_guard  <= 1'b0;
      r_sticky <= w_sticky;
    end else if ((r_state == S_ALIGN) && (r_cnt != 5'd0)) begin
      r_work   <= r_work >> 1;
      r_guard  <= r_work[0];
      r_sticky <= r_sticky | r_guard;
      r_cnt    <= r_cnt - 5'd1;
    end
  end

  // Result registers: written in ROUND, held through OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fixed <= '0;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
      r_inex  <= 1'b0;
    end else if (r_state == S_ROUND) begin
      r_ovf  <= 1'b0;
      r_inv  <= 1'b0;
      r_inex <= 1'b0;
      case (r_class)
        C_NORM: begin
          r_fixed <= w_res;
          r_inex  <= r_guard | r_sticky;
        end
        C_SAT: begin
          r_fixed <= f_sat(r_sign);
          r_ovf   <= 1'b1;
        end
        C_NAN: begin
          r_fixed <= 32'sh7FFF_FFFF;
          r_inv   <= 1'b1;
        end
        default: begin
          r_fixed <= '0;
          r_inex  <= r_sticky;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floatp2fixedp_seq.sv
// Scoreboard bench for floatp2fixedp_seq: directed vectors with hand-computed
// results, backpressure, mid-operation reset and a random sweep against an
// arithmetic round-to-nearest-even reference.
module tb_floatp2fixedp_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fixedq16;
  logic        ovf;
  logic        invalid;
  logic        inexact;

  typedef struct {
    logic [31:0] fx;
    logic        ovf;
    logic        inv;
    logic        inex;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_hs  = -1;
  int   first_edge = 0;
  bit   seen     = 0;

  floatp2fixedp_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float32(float32), .out_valid(out_valid), .out_ready(out_ready),
    .fixedq16(fixedq16), .ovf(ovf), .invalid(invalid), .inexact(inexact)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t ex;
    if (rst) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        first_edge = cyc;
      end
      if (out_ready) begin
        seen = 0;
        last_hs = cyc + 1;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected no output", fixedq16);
        end else begin
          ex = sb.pop_front();
          chk("fixedq16", fixedq16, ex.fx);
          chk("ovf", 32'(ovf), 32'(ex.ovf));
          chk("invalid", 32'(invalid), 32'(ex.inv));
          chk("inexact", 32'(inexact), 32'(ex.inex));
          chk("latency", 32'(first_edge - ex.acc), 32'(ex.lat));
        end
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] fx, input logic o, input logic i,
                              input logic x, input int lat);
    exp_t r;
    r.fx = fx; r.ovf = o; r.inv = i; r.inex = x; r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // Reference: exact value M*2^k with explicit RNE on the discarded remainder.
  function automatic exp_t model(input logic [31:0] f);
    exp_t        r;
    logic        s;
    int          e, k, sh;
    logic [23:0] mm;
    longint      mag, q, rem, half;
    r = mk(32'h0, 1'b0, 1'b0, 1'b0, 2);
    s = f[31];
    e = int'(f[30:23]);
    mm = {1'b1, f[22:0]};
    if (e == 255) begin
      if (f[22:0] != 0) begin
        r.fx = 32'h7FFF_FFFF; r.inv = 1;
      end else begin
        r.fx = s ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1;
      end
    end else if (e == 0) begin
      r.inex = (f[22:0] != 0);
    end else begin
      k = e - 134;
      if (k >= 0) begin
        mag = 0;
        if (k <= 8) mag = longint'(mm) << k;
        if (k <= 8 && (mag <= 64'h7FFF_FFFF || (s && mag == 64'h8000_0000)))
          r.fx = s ? 32'(-mag) : 32'(mag);
        else begin
          r.fx = s ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1;
        end
      end else begin
        sh = -k;
        r.lat = ((sh > 26) ? 26 : sh) + 2;
        if (sh > 30) begin
          q = 0; r.inex = 1;
        end else begin
          q = longint'(mm) >> sh;
          rem = longint'(mm) & ((longint'(1) << sh) - 1);
          half = longint'(1) << (sh - 1);
          if (rem > half || (rem == half && q[0])) q = q + 1;
          r.inex = (rem != 0);
        end
        r.fx = s ? 32'(-q) : 32'(q);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer f until accepted; optionally record the expected result.
  task automatic send(input logic [31:0] f, input exp_t ex, input bit push, output int acc);
    bit done;
    done = 0;
    acc = -1;
    in_valid = 1;
    float32 = f;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) begin
        acc = cyc + 1;
        ex.acc = acc;
        if (push) sb.push_back(ex);
        done = 1;
      end
      tick();
    end
    in_valid = 0;
    float32 = $urandom;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept of %h", f);
    end
  endtask

  task automatic sendx(input logic [31:0] f, input exp_t ex);
    int a;
    send(f, ex, 1'b1, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  initial begin
    int          acc;
    logic [31:0] f;
    bit          got;
    rst = 1; in_valid = 0; out_ready = 1; float32 = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fixedq16", fixedq16, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_invalid", 32'(invalid), 32'd0);
    chk("rst_inexact", 32'(inexact), 32'd0);

    // Basic conversions, rounding ties, specials and range boundaries.
    sendx(32'h40600000, mk(32'h0003_8000, 0, 0, 0, 8));
    sendx(32'h3FA00000, mk(32'h0001_4000, 0, 0, 0, 9));
    sendx(32'h37000000, mk(32'h0000_0000, 0, 0, 1, 26));
    sendx(32'h37C00000, mk(32'h0000_0002, 0, 0, 1, 25));
    sendx(32'hB7C00000, mk(32'hFFFF_FFFE, 0, 0, 1, 25));
    sendx(32'h47000000, mk(32'h7FFF_FFFF, 1, 0, 0, 2));
    sendx(32'hC7000000, mk(32'h8000_0000, 0, 0, 0, 2));
    sendx(32'hFF800000, mk(32'h8000_0000, 1, 0, 0, 2));
    sendx(32'h7FC00000, mk(32'h7FFF_FFFF, 0, 1, 0, 2));
    sendx(32'h00000001, mk(32'h0000_0000, 0, 0, 1, 2));
    sendx(32'h80000000, mk(32'h0000_0000, 0, 0, 0, 2));
    sendx(32'h46FFFE00, mk(32'h7FFF_0000, 0, 0, 0, 2));
    sendx(32'h437F0000, mk(32'h00FF_0000, 0, 0, 0, 2));
    sendx(32'h33800000, mk(32'h0000_0000, 0, 0, 1, 28));
    drain();

    // Backpressure: hold out_ready low, offer a second input during the stall.
    out_ready = 0;
    sendx(32'h42C80000, mk(32'h0064_0000, 0, 0, 0, 3));
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1;
      else tick();
    end
    chk("bp_out_valid_seen", 32'(got), 32'd1);
    in_valid = 1;
    float32 = 32'h3FA00000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_fixedq16", fixedq16, 32'h0064_0000);
      chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    send(32'h3FA00000, mk(32'h0001_4000, 0, 0, 0, 9), 1'b1, acc);
    chk("bp_accept_edge", 32'(acc), 32'(last_hs + 1));
    drain();

    // Reset in the middle of a long alignment.
    send(32'h3A800000, mk(32'h0, 0, 0, 0, 0), 1'b0, acc);
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_fixedq16", fixedq16, 32'h0);
    chk("mid_rst_flags", {29'd0, ovf, invalid, inexact}, 32'd0);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) got = 1;
    end
    chk("mid_rst_no_output", 32'(got), 32'd0);
    sendx(32'h40600000, mk(32'h0003_8000, 0, 0, 0, 8));
    drain();

    // Random sweep against the reference model.
    for (int n = 0; n < 1500; n++) begin
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(100, 150));
      sendx(f, model(f));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
